// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared constants and saturation helper for the IIR biquad datapath
package iir_pkg;

    localparam int BIT_NO = 32;
    localparam int CK     = 11;
    localparam int OUT_W  = 16;

    // Signed clamp of v into the n-bit two's complement range; result stays 64 bits wide.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/iir_sync_fifo.sv
// rtl/iir_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module iir_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (PW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/iir_decim_out.sv
// rtl/iir_decim_out.sv - boxcar decimator, saturating requantizer and output FIFO for the IIR filter
module iir_decim_out
    import iir_pkg::*;
#(
    parameter int bit_no = BIT_NO,
    parameter int OUT_W  = 16,
    parameter int DECIM  = 4,
    parameter int SHIFT  = 0,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [bit_no-1:0]        in,
    input  logic                     in_en,
    input  logic                     flush,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_flag,
    output logic                     ovf_flag
);

    localparam int LOG_D = $clog2(DECIM);
    localparam int AW    = bit_no + LOG_D;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] avg_r;
    logic signed [AW-1:0] q;
    logic [LOG_D-1:0]     phase;
    logic                 avg_vld;
    logic signed [63:0]   q_wide;
    logic signed [63:0]   q_clip;
    logic                 clipped;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [OUT_W-1:0]     push_data;

    assign sum = acc + $signed({{LOG_D{in[bit_no-1]}}, in});

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            phase   <= '0;
            avg_r   <= '0;
            avg_vld <= 1'b0;
        end else if (flush) begin
            acc     <= '0;
            phase   <= '0;
            avg_vld <= 1'b0;
        end else begin
            avg_vld <= 1'b0;
            if (in_en) begin
                if (phase == LOG_D'(DECIM - 1)) begin
                    avg_r   <= sum;
                    avg_vld <= 1'b1;
                    acc     <= '0;
                    phase   <= '0;
                end else begin
                    acc   <= sum;
                    phase <= phase + 1'b1;
                end
            end
        end
    end

    // Averaging and fraction dropping fold into one floor-rounding shift.
    assign q         = avg_r >>> (LOG_D + SHIFT);
    assign q_wide    = $signed({{(64 - AW){q[AW-1]}}, q});
    assign q_clip    = sat_clip(q_wide, OUT_W);
    assign clipped   = (q_clip != q_wide);
    assign push_data = q_clip[OUT_W-1:0];

    // A flush on the push edge discards the pending result as well.
    assign push      = avg_vld && !flush;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (push && clipped) begin
                sat_flag <= 1'b1;
            end
            if (push && full && !pop) begin
                ovf_flag <= 1'b1;
            end
        end
    end

    iir_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (push_data),
        .pop     (pop),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

endmodule

// File: doc/iir_decim_out.md
# iir_decim_out

Downstream stage of the 32-bit IIR biquad. Consumes the filter's signed `bit_no`-bit output stream, averages each block of `DECIM` consecutive qualified samples (boxcar decimation), requantizes the result to `OUT_W` bits with saturation, and buffers it in a small FIFO. The FIFO drains through a valid/ready handshake toward the output consumer (DAC or serializer). The block also reports sticky saturation and overflow flags.

## Interface
- `bit_no`, 32: input sample width, signed two's complement, same format as the filter output.
- `OUT_W`, 16: output sample width, signed.
- `DECIM`, 4: decimation factor. Must be a power of two, ≥2. `LOG_D = log2(DECIM)`.
- `SHIFT`, 0: extra arithmetic right shift applied after averaging, for dropping fraction bits.
- `DEPTH`, 8: FIFO depth. Must be a power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in` in `bit_no`: filter output sample.
- `in_en` in 1: `in` is a new sample this cycle.
- `flush` in 1: discard the partial block.
- `out_data` out `OUT_W`: FIFO head sample (show-ahead).
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts `out_data`.
- `level` out `log2(DEPTH)+1`: FIFO occupancy.
- `sat_flag` out 1: sticky, set when any output saturated.
- `ovf_flag` out 1: sticky, set when a result was dropped because the FIFO was full.

## Operation
- **Accumulate stage.**
  - Registers: `acc` (`bit_no+LOG_D` bits, signed) and `phase` (0..DECIM-1).
  - On an edge with `in_en=1`: `acc <= acc + sext(in)` and `phase` increments.
  - When `phase==DECIM-1`, the sum including the current sample is registered into `avg_r` and `avg_vld` is set. In the same edge, `acc` is cleared to 0 and `phase` to 0.
- **Requantize stage.**
  - Computes `q = (avg_r >>> (LOG_D+SHIFT))`: arithmetic shift, floor rounding.
  - Clamps `q` to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If clamping changed the value, `sat_flag <= 1`.
  - The clamped result is pushed into the FIFO on the edge after `avg_vld`.
- **FIFO.**
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - Push when full without a pop: the result is dropped, `ovf_flag <= 1`, and contents are unchanged.
  - Pop occurs when `out_valid && out_ready`.
  - Simultaneous push and pop on a non-empty FIFO: `level` is unchanged and order is preserved.
  - Pointers wrap modulo `DEPTH`.
- **Flush.**
  - On an edge with `flush=1`: `acc<=0`, `phase<=0`, and `avg_vld<=0`, so a pending result is discarded.
  - A simultaneous `in_en` sample is discarded. `flush` wins.
  - FIFO contents and flags are kept.
- **Reset.**
  - Clears `acc`, `phase`, `avg_vld`, and the FIFO pointers.
  - Output values after reset: `out_valid=0`, `out_data=0`, `level=0`, `sat_flag=0`, `ovf_flag=0`.
  - Reset mid-block discards partial sums. Reset has priority over everything.
- `in` is ignored when `in_en=0`. The accumulator cannot overflow, because its width is `bit_no+LOG_D`.

## Timing
- Last sample of a block accepted at edge k → `avg_vld` high after edge k → FIFO write at edge k+1.
- With an empty FIFO, `out_valid=1` and `out_data` is valid in the cycle after edge k+1. Latency is 2 clocks.
- `out_data` is stable while `out_valid=1 && out_ready=0`.
- After a pop at edge p, the next entry (if any) is presented after edge p.
- Sustained throughput is 1 result per `DECIM` qualified samples. The FIFO never backpressures the input; excess results drop with `ovf_flag`.
- `level` updates on the same edge as the push/pop.

## Structure
- Shared package `iir_pkg`:
  - Constants `BIT_NO=32`, `CK=11`, `OUT_W=16`.
  - A `sat_clip` function (signed clamp to N bits) for reuse by other requantizing stages.
- Sub-module `iir_sync_fifo`:
  - Parameters `W` and `DEPTH`.
  - Show-ahead read, `push`/`pop`/`full`/`empty`/`level` ports.
  - Handles the full+pop same-cycle case internally.
- The top level holds the accumulate/requantize pipeline and the flags.

## Test plan
- DECIM=4, samples 100, 200, 300, 400 with `in_en=1`, `out_ready=1` → `out_data=250`, `out_valid` pulses 1 cycle, 2 clocks after the 4th sample. `sat_flag=0`.
- Samples -1, -1, -1, -2 → sum -5, `out_data=-2` (floor).
- 4×40000 → `out_data=32767`, `sat_flag=1`. After reset, 4×-40000 → `-32768`.
- `out_ready=0`, 9 full blocks of the constant value 7:
  - `level=8`, `ovf_flag=1` after the 9th result.
  - Then `out_ready=1` drains exactly 8 values of 7.
  - `level` returns to 0 and `out_valid=0`.
- FIFO full, with a new result arriving on the same edge as a pop → `level` stays 8, `ovf_flag` stays 0, and the new value appears last in drain order.
- Two samples of a block (10, 20), then `flush` (or `reset`) asserted with `in_en=1`. Then 4×8 → `out_data=8`, so the partial sums were discarded.
